pwm_peripheral: RTL
===================

PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 SHALL have parameter PRESCALE, default 10: number of clk cycles per PWM counter tick (legal range 1..1023).
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port en_reg_out_7_0  input  8  output enables for out[7:0].
REQ-005 SHALL have port en_reg_out_15_8  input  8  output enables for out[15:8].
REQ-006 SHALL have port en_reg_pwm_7_0  input  8  PWM-mode selects for out[7:0].
REQ-007 SHALL have port en_reg_pwm_15_8  input  8  PWM-mode selects for out[15:8].
REQ-008 SHALL have port pwm_duty_cycle  input  8  requested duty, in 1/256 of a period.
REQ-009 SHALL have port out  output  16  registered drive outputs.
REQ-010 SHALL have port period_start  output  1  one-clk pulse marking PWM period start.
REQ-011 SHALL treat all inputs as synchronous to clk; they come from the SPI register file and receive no synchronisers.

Function
REQ-012 SHALL contain a prescaler counter that counts 0..PRESCALE-1 and wraps to 0; a tick occurs in each cycle where it equals PRESCALE-1.
REQ-013 SHALL contain an 8-bit pwm_cnt that increments once per tick and wraps 255->0; period = 256*PRESCALE clk cycles.
REQ-014 SHALL keep an 8-bit duty_shadow, loaded from pwm_duty_cycle only on a tick where pwm_cnt==255, i.e. on the edge where pwm_cnt becomes 0.
REQ-015 SHALL ignore pwm_duty_cycle changes mid-period; the new duty takes effect at the next period start (glitch-free update).
REQ-016 SHALL define pwm_level = 1 when duty_shadow==8'hFF (full-on, no low slot), else (pwm_cnt < duty_shadow).
REQ-017 SHALL give duty_shadow==0 a constant-low pwm_level.
REQ-018 SHALL register out[i] each clk as: en_out[i]==0 -> 0; en_out[i]==1 and en_pwm[i]==0 -> 1; both 1 -> pwm_level.
REQ-019 SHALL make enable/select changes visible on out exactly one clk after they are sampled; they are not period-buffered.
REQ-020 SHALL register period_start high for exactly one clk after each edge where pwm_cnt wraps 255->0, and low otherwise.
REQ-021 SHALL, for PRESCALE==1, tick every clk and keep all other rules unchanged.

Reset
REQ-022 SHALL, on any clk edge with rst_n==0, set: prescaler=0, pwm_cnt=0, duty_shadow=0, out=16'h0000, period_start=0.
REQ-023 SHALL let reset override everything, including mid-period or coincident tick/wrap; counting restarts from 0 on the first edge with rst_n==1.
REQ-024 SHALL hold PWM-mode outputs low after reset until the first duty_shadow load (256*PRESCALE clks after release).

Verification
REQ-025 SHALL cover: reset, then en_reg_out_7_0=8'h01, en_reg_pwm_7_0=0 -> out=16'h0001 one clk after inputs applied; all other bits 0.
REQ-026 SHALL cover: PRESCALE=10, out[0] PWM-enabled, duty=8'h80 -> after the first period_start, out[0] is high 1280 clks and low 1280 clks per 2560-clk period.
REQ-027 SHALL cover: duty=8'hFF -> out[0] constantly 1; duty=8'h00 -> out[0] constantly 0 across at least 2 periods.
REQ-028 SHALL cover: duty changed 8'h40->8'hC0 mid-period -> current period high time stays 640 clks; the next period is 1920 clks high.
REQ-029 SHALL cover: rst_n low for one clk mid-period -> out=0 and period_start=0 next clk; the next period_start occurs 2560 clks after release.
REQ-030 SHALL cover: en_reg_out toggled mid-period with PWM active -> out bit follows within 1 clk, and PWM phase is unaffected.

Source files
------------

// File: rtl/pwm_peripheral.sv
// Sixteen-channel drive block: each output is off, statically on, or driven by a shared PWM waveform
// whose duty is latched only at period boundaries so mid-period writes never glitch the output.
module pwm_peripheral #(
    parameter int PRESCALE = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam logic [9:0] PRE_LAST = 10'(PRESCALE - 1);

    logic [9:0]  prescaler;
    logic [7:0]  pwm_cnt;
    logic [7:0]  duty_shadow;
    logic        tick;
    logic        wrap;
    logic        pwm_level;
    logic [15:0] en_out;
    logic [15:0] en_pwm;

    // Full scale is special-cased so 8'hFF has no low slot at pwm_cnt==255.
    function automatic logic level_of(input logic [7:0] cnt, input logic [7:0] duty);
        return (duty == 8'hFF) ? 1'b1 : (cnt < duty);
    endfunction

    assign tick      = (prescaler == PRE_LAST);
    assign wrap      = tick && (pwm_cnt == 8'hFF);
    assign pwm_level = level_of(pwm_cnt, duty_shadow);
    assign en_out    = {en_reg_out_15_8, en_reg_out_7_0};
    assign en_pwm    = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler    <= '0;
            pwm_cnt      <= '0;
            duty_shadow  <= '0;
            out          <= '0;
            period_start <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 10'd1;
            if (tick) begin
                pwm_cnt <= pwm_cnt + 8'd1;
            end
            if (wrap) begin
                duty_shadow <= pwm_duty_cycle;
            end
            period_start <= wrap;
            // Enables are not period-buffered; only the PWM waveform itself is.
            out <= en_out & (~en_pwm | {16{pwm_level}});
        end
    end

endmodule
